// File: rtl/step_sequencer.sv
// Round-robin controller that grants one of two requesters a burst of N enable
// steps on a shared machine. Optional abort is enabled with STEP_SEQ_ABORT_EN.
module step_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [CNT_W-1:0] CNT0,
  input  logic [CNT_W-1:0] CNT1,
  input  logic             A,
  input  logic             B,
  input  logic             Q,
`ifdef STEP_SEQ_ABORT_EN
  input  logic             ABORT,
  output logic             ABORTED,
`endif
  output logic             E,
  output logic             GNT0,
  output logic             GNT1,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       SNAP,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             gsel, gsel_nx;
  logic             pri, pri_nx;
  logic             win;
  logic [CNT_W-1:0] cnt_sel;
  logic             abort_hit;
  logic [2:0]       snap_r;

`ifdef STEP_SEQ_ABORT_EN
  logic aborted_r;
  assign abort_hit = ABORT && (state == S_RUN);

  always_ff @(posedge CLK) begin
    if (RST) aborted_r <= 1'b0;
    else     aborted_r <= abort_hit;
  end

  assign ABORTED = aborted_r && (state == S_DONE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      rem    <= '0;
      gsel   <= 1'b0;
      pri    <= 1'b0;
      snap_r <= 3'b000;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      gsel  <= gsel_nx;
      pri   <= pri_nx;
      if (state == S_DONE) snap_r <= {A, B, Q};
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    gsel_nx  = gsel;
    pri_nx   = pri;
    win      = 1'b0;
    cnt_sel  = '0;
    case (state)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          // pri only matters when both are asking
          win      = (REQ0 && REQ1) ? pri : REQ1;
          cnt_sel  = win ? CNT1 : CNT0;
          gsel_nx  = win;
          rem_nx   = cnt_sel;
          state_nx = (cnt_sel != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort_hit) begin
          rem_nx   = '0;
          state_nx = S_DONE;
        end else begin
          rem_nx = rem - 1'b1;
          if (rem == {{(CNT_W-1){1'b0}}, 1'b1}) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        pri_nx   = ~gsel;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // E is gated by RST so a reset cycle never advances the machine
  assign E         = (state == S_RUN) && !RST && !abort_hit;
  assign BUSY      = (state != S_IDLE);
  assign GNT0      = BUSY && !gsel;
  assign GNT1      = BUSY && gsel;
  assign DONE      = (state == S_DONE);
  assign SNAP      = snap_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: a 2-bit counter stands in for the controlled
// machine; grants, step counts and snapshots are predicted arithmetically.
module tb_step_sequencer;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] cnt0, cnt1;
  logic       e, gnt0, gnt1, busy, done;
  logic [2:0] snap;
  logic [1:0] dbg_state;
  logic [1:0] ab;
  logic       q;
`ifdef STEP_SEQ_ABORT_EN
  logic       abort, aborted;
`endif

  int errors = 0;
  int checks = 0;
  int pri_m  = 0;  // expected round-robin pointer
  int ab_m   = 0;  // expected machine count, mod 4
  logic [2:0] exp_q[$];

  step_sequencer #(.CNT_W(4)) dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .CNT0(cnt0), .CNT1(cnt1),
    .A(ab[1]), .B(ab[0]), .Q(q),
`ifdef STEP_SEQ_ABORT_EN
    .ABORT(abort), .ABORTED(aborted),
`endif
    .E(e), .GNT0(gnt0), .GNT1(gnt1), .BUSY(busy), .DONE(done), .SNAP(snap),
    .dbg_state(dbg_state)
  );

  // clock / machine
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ab = 2'b00;
  always @(posedge clk) if (e) ab <= ab + 2'd1;
  assign q = ab[1] & ~ab[0];

  function automatic logic [2:0] abq(input int v);
    logic [1:0] t;
    t = v[1:0];
    return {t, t[1] & ~t[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watches cycles until DONE; optionally scrambles counts after the grant edge.
  task automatic watch_grant(input int bound, input bit scramble, output int id,
                             output int n_e, output int lat, output logic held);
    id = -1; n_e = 0; lat = 0; held = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      tick();
      if (id < 0 && (gnt0 || gnt1)) id = gnt1 ? 1 : 0;
      if (e) n_e++;
      if (scramble && c == 1) begin
        cnt0 = 4'($urandom_range(0, 15));
        cnt1 = 4'($urandom_range(0, 15));
      end
      if (done) begin
        lat  = c;
        held = (id == 1) ? gnt1 : (id == 0) ? gnt0 : 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0; cnt0 = 0; cnt1 = 0;
`ifdef STEP_SEQ_ABORT_EN
    abort = 0;
`endif
    tick(); tick();
    checks++; if (e !== 1'b0)      begin errors++; $display("FAIL reset_e got=%b exp=0", e); end
    checks++; if (gnt0 !== 1'b0)   begin errors++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    checks++; if (gnt1 !== 1'b0)   begin errors++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (snap !== 3'b000) begin errors++; $display("FAIL reset_snap got=%b exp=000", snap); end
    rst = 1'b0;
    tick();
    pri_m = 0;
  endtask

  task automatic test_single();
    int id, n_e, lat; logic held;
    req0 = 1; cnt0 = 4'd3;
    ab_m = (ab_m + 3) % 4;
    watch_grant(30, 1'b1, id, n_e, lat, held);
    req0 = 0;
    pri_m = 1;
    checks++; if (id !== 0)    begin errors++; $display("FAIL single_gnt got=%0d exp=0", id); end
    checks++; if (n_e !== 3)   begin errors++; $display("FAIL single_e_count got=%0d exp=3", n_e); end
    checks++; if (lat !== 4)   begin errors++; $display("FAIL single_done_cycle got=%0d exp=4", lat); end
    checks++; if (held !== 1)  begin errors++; $display("FAIL single_gnt_held got=%b exp=1", held); end
    checks++; if (busy !== 1)  begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    checks++; if (done !== 0)  begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    checks++; if (snap !== abq(ab_m)) begin errors++; $display("FAIL single_snap got=%b exp=%b", snap, abq(ab_m)); end
  endtask

  task automatic test_contention();
    int id, n_e, lat; logic held;
    req0 = 1; req1 = 1; cnt0 = 4'd2; cnt1 = 4'd1;
    // pointer is 1 after test_single, so requester 1 wins first
    exp_q.push_back(pri_m == 0 ? 3'd0 : 3'd1);
    exp_q.push_back(pri_m == 0 ? 3'd1 : 3'd0);
    for (int g = 0; g < 2; g++) begin
      logic [2:0] w;
      int n;
      w = exp_q.pop_front();
      n = (w == 3'd1) ? 1 : 2;
      ab_m = (ab_m + n) % 4;
      watch_grant(30, 1'b0, id, n_e, lat, held);
      if (w == 3'd0) req0 = 0; else req1 = 0;
      pri_m = (w == 3'd1) ? 0 : 1;
      checks++; if (id !== int'(w)) begin errors++; $display("FAIL contend_gnt%0d got=%0d exp=%0d", g, id, w); end
      checks++; if (n_e !== n)      begin errors++; $display("FAIL contend_e%0d got=%0d exp=%0d", g, n_e, n); end
      checks++; if (lat !== n + 1 + g) begin errors++; $display("FAIL contend_lat%0d got=%0d exp=%0d", g, lat, n + 1 + g); end
    end
    tick();
    checks++; if (snap !== abq(ab_m)) begin errors++; $display("FAIL contend_snap got=%b exp=%b", snap, abq(ab_m)); end
  endtask

  task automatic test_zero();
    int id, n_e, lat; logic held;
    req1 = 1; cnt1 = 4'd0;
    watch_grant(10, 1'b0, id, n_e, lat, held);
    req1 = 0;
    pri_m = 0;
    checks++; if (id !== 1)   begin errors++; $display("FAIL zero_gnt got=%0d exp=1", id); end
    checks++; if (n_e !== 0)  begin errors++; $display("FAIL zero_e got=%0d exp=0", n_e); end
    checks++; if (lat !== 1)  begin errors++; $display("FAIL zero_lat got=%0d exp=1", lat); end
    checks++; if (held !== 1) begin errors++; $display("FAIL zero_gnt_held got=%b exp=1", held); end
    tick();
    checks++; if (snap !== abq(ab_m)) begin errors++; $display("FAIL zero_snap got=%b exp=%b", snap, abq(ab_m)); end
  endtask

  task automatic test_fairness();
    int id, n_e, lat; logic held;
    req0 = 1; req1 = 1; cnt0 = 4'd1; cnt1 = 4'd1;
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(3'(pri_m));
      pri_m = 1 - pri_m;
    end
    for (int g = 0; g < 4; g++) begin
      logic [2:0] w;
      w = exp_q.pop_front();
      ab_m = (ab_m + 1) % 4;
      watch_grant(20, 1'b0, id, n_e, lat, held);
      if (g == 3) begin req0 = 0; req1 = 0; end
      checks++; if (id !== int'(w)) begin errors++; $display("FAIL fair_gnt%0d got=%0d exp=%0d", g, id, w); end
      checks++; if (n_e !== 1)      begin errors++; $display("FAIL fair_e%0d got=%0d exp=1", g, n_e); end
    end
    tick();
    checks++; if (snap !== abq(ab_m)) begin errors++; $display("FAIL fair_snap got=%b exp=%b", snap, abq(ab_m)); end
  endtask

  task automatic test_reset_midrun();
    int ab0;
    ab0 = int'(ab);
    req0 = 1; cnt0 = 4'd5;
    tick();  // first E cycle
    tick();  // second E cycle; deassert is ignored
    req0 = 0;
    tick();  // third E cycle is the reset cycle
    rst = 1;
    #1;
    checks++; if (e !== 0) begin errors++; $display("FAIL rstrun_e_now got=%b exp=0", e); end
    tick();
    rst = 0;
    checks++; if (e !== 0)     begin errors++; $display("FAIL rstrun_e got=%b exp=0", e); end
    checks++; if (busy !== 0)  begin errors++; $display("FAIL rstrun_busy got=%b exp=0", busy); end
    checks++; if (gnt0 !== 0)  begin errors++; $display("FAIL rstrun_gnt0 got=%b exp=0", gnt0); end
    checks++; if (done !== 0)  begin errors++; $display("FAIL rstrun_done got=%b exp=0", done); end
    checks++; if (snap !== 3'b000) begin errors++; $display("FAIL rstrun_snap got=%b exp=000", snap); end
    checks++; if (((int'(ab) - ab0 + 4) % 4) !== 2) begin errors++; $display("FAIL rstrun_steps got=%0d exp=2", (int'(ab) - ab0 + 4) % 4); end
    tick();
    checks++; if (done !== 0)  begin errors++; $display("FAIL rstrun_no_done got=%b exp=0", done); end
    ab_m = (ab_m + 2) % 4;
    pri_m = 0;
  endtask

`ifdef STEP_SEQ_ABORT_EN
  task automatic test_abort();
    req0 = 1; cnt0 = 4'd4;
    tick();  // first E cycle
    tick();
    abort = 1;
    #1;
    checks++; if (e !== 0) begin errors++; $display("FAIL abort_e got=%b exp=0", e); end
    tick();
    abort = 0; req0 = 0;
    checks++; if (done !== 1)    begin errors++; $display("FAIL abort_done got=%b exp=1", done); end
    checks++; if (aborted !== 1) begin errors++; $display("FAIL abort_flag got=%b exp=1", aborted); end
    ab_m = (ab_m + 1) % 4;
    pri_m = 1;
    tick();
    checks++; if (aborted !== 0) begin errors++; $display("FAIL abort_flag_clr got=%b exp=0", aborted); end
    checks++; if (snap !== abq(ab_m)) begin errors++; $display("FAIL abort_snap got=%b exp=%b", snap, abq(ab_m)); end
  endtask
`endif

  task automatic test_random();
    int id, n_e, lat, r, w, n; logic held;
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(1, 3);
      req0 = r[0]; req1 = r[1];
      cnt0 = 4'($urandom_range(0, 7));
      cnt1 = 4'($urandom_range(0, 7));
      w = (r == 3) ? pri_m : (r == 2 ? 1 : 0);
      n = (w == 1) ? int'(cnt1) : int'(cnt0);
      ab_m = (ab_m + n) % 4;
      exp_q.push_back(abq(ab_m));
      watch_grant(25, 1'b1, id, n_e, lat, held);
      req0 = 0; req1 = 0;
      pri_m = 1 - w;
      checks++; if (id !== w || n_e !== n || lat !== n + 1 || held !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d got id=%0d e=%0d lat=%0d held=%b exp id=%0d e=%0d lat=%0d held=1",
                 it, id, n_e, lat, held, w, n, n + 1);
      end
      tick();
      begin
        logic [2:0] xs;
        xs = exp_q.pop_front();
        checks++; if (snap !== xs || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand%0d_snap got snap=%b busy=%b exp snap=%b busy=0", it, snap, busy, xs);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero();
    test_fairness();
    test_reset_midrun();
`ifdef STEP_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
